palette_arbiter: RTL and testbench
==================================

PALETTE_ARBITER -- requirements
Module: palette_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 3, the number of requesters sharing the palette lookup.
REQ-002 The module SHALL have parameter IDX_W, default 4, the palette index width (16 entries).
REQ-003 The module SHALL have parameter COLOR_W, default 12, the RGB444 colour width.
REQ-004 The module SHALL have parameter TRANSP_IDX, default 4'd0, the palette index treated as transparent.
REQ-005 The module SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port req_valid, input, NUM_REQ bits: per-requester lookup request.
REQ-008 The module SHALL have port req_idx, input, NUM_REQ*IDX_W bits: packed palette indices, requester i at bits [i*IDX_W +: IDX_W].
REQ-009 The module SHALL have port req_ready, output, NUM_REQ bits: one-hot grant, at most one bit set per cycle.
REQ-010 The module SHALL have port rom_addr, output, IDX_W bits: registered address to the combinational palette ROM.
REQ-011 The module SHALL have port rom_color, input, COLOR_W bits: ROM data, valid in the same cycle as rom_addr.
REQ-012 The module SHALL have port rsp_valid, output, NUM_REQ bits: one-hot response strobe naming the requester that owns rsp_color.
REQ-013 The module SHALL have port rsp_color, output, COLOR_W bits: looked-up colour.
REQ-014 The module SHALL have port rsp_transp, output, 1 bit: high with rsp_valid when the looked-up index equals TRANSP_IDX.

Function
REQ-015 The module SHALL compute req_ready combinationally from req_valid and the round-robin pointer rr_ptr: grant the first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ; req_ready SHALL be 0 when no req_valid is set.
REQ-016 The module SHALL treat a transfer as occurring in a cycle where req_valid[i] and req_ready[i] are both 1; accepting at most one transfer per cycle gives throughput 1 lookup/cycle.
REQ-017 On a transfer from requester g, the module SHALL update rr_ptr to (g+1) mod NUM_REQ at the next edge; without a transfer, rr_ptr SHALL hold.
REQ-018 Stage 1: at the edge ending transfer cycle T, the module SHALL load rom_addr with req_idx of g, load s1_owner with one-hot g, and set s1_valid to 1; otherwise it SHALL clear s1_valid and hold rom_addr.
REQ-019 Stage 2: at the edge ending cycle T+1, the module SHALL load rsp_color from rom_color, set rsp_valid to s1_owner if s1_valid is 1 (else 0), and set rsp_transp to (rom_addr == TRANSP_IDX) && s1_valid.
REQ-020 Latency SHALL be exactly 2 cycles, with rsp_valid asserted during cycle T+2 for one cycle per transfer; back-to-back transfers SHALL yield back-to-back responses in grant order.
REQ-021 Responses SHALL NOT be back-pressured; requesters SHALL capture rsp_color in the cycle rsp_valid is high.
REQ-022 A requester that drops req_valid before being granted SHALL lose the request with no response; the pointer SHALL be unaffected.
REQ-023 With all requesters valid continuously, the module SHALL issue grants in the strict rotation 0,1,2,0,... and SHALL NOT grant any requester twice before each other valid requester has been granted once.
REQ-024 rsp_color SHALL hold its last value while rsp_valid is 0.

Reset
REQ-025 While Reset_n is 0, the module SHALL asynchronously set rr_ptr=0, rom_addr=0, s1_valid=0, s1_owner=0, rsp_valid=0, rsp_color=0 and rsp_transp=0; req_ready SHALL be 0 regardless of req_valid.
REQ-026 Reset asserted mid-pipeline SHALL discard in-flight lookups, with no rsp_valid produced for them after release.
REQ-027 After Reset_n deasserts, the first grant SHALL be available in the next cycle, with priority starting at requester 0.

Verification
REQ-028 Scenario single lookup: only req_valid[1]=1 with idx 4'd1 for one cycle -> req_ready=3'b010 in that cycle; two cycles later rsp_valid=3'b010, rsp_color=12'hDDB and rsp_transp=0.
REQ-029 Scenario transparent index: req 0 with idx 4'd0 -> rsp_valid=3'b001, rsp_color=12'h232 and rsp_transp=1 at T+2.
REQ-030 Scenario fairness: all three requesters continuously valid for 6 cycles -> grants 001,010,100,001,010,100 and responses in the same order, each 2 cycles later.
REQ-031 Scenario skip idle: rr_ptr=1 and only req_valid[0]=1 -> grant 001 the same cycle and rr_ptr becomes 1.
REQ-032 Scenario reset mid-flight: grant in cycle T, then Reset_n low during T+1 -> rsp_valid stays 0 through and after release, and the next grant goes to the lowest-indexed valid requester from 0.
REQ-033 Scenario back-to-back: req 2 with idx 8 then req 0 with idx 15 on consecutive cycles -> consecutive responses 12'hFFF to requester 2, then 12'hD93 to requester 0.

Source files
------------

// File: rtl/palette_arbiter.sv
// Round-robin arbiter in front of a shared combinational palette ROM.
// A granted request takes two cycles. In the first, the index is registered as rom_addr. In the
// second, the ROM colour is registered into rsp_color, tagged with the owner of the request.
module palette_arbiter #(
  parameter int unsigned      NUM_REQ    = 3,
  parameter int unsigned      IDX_W      = 4,
  parameter int unsigned      COLOR_W    = 12,
  parameter logic [IDX_W-1:0] TRANSP_IDX = '0
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IDX_W-1:0]         rom_addr,
  input  logic [COLOR_W-1:0]       rom_color,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [COLOR_W-1:0]       rsp_color,
  output logic                     rsp_transp
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]    cand;
  logic [PtrW-1:0]    gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0]   gnt_word;

  logic [IDX_W-1:0]   rom_addr_q;
  logic               s1_valid_q;
  logic [NUM_REQ-1:0] s1_owner_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [COLOR_W-1:0] rsp_color_q;
  logic               rsp_transp_q;

  // Grant the first valid requester at or after rr_ptr, wrapping; nothing is granted while in reset.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PtrW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any          = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
    if (!Reset_n) begin
      gnt_onehot = '0;
      gnt_any    = 1'b0;
    end
  end

  assign gnt_word = req_idx[gnt_idx*IDX_W +: IDX_W];

  // The pointer moves to the requester after the one just granted, and holds when idle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Two-stage lookup pipeline. Reset drops any lookup that is in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr_q     <= '0;
      rom_addr_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_owner_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_color_q  <= '0;
      rsp_transp_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= gnt_any;
      if (gnt_any) begin
        rom_addr_q <= gnt_word;
        s1_owner_q <= gnt_onehot;
      end
      rsp_valid_q  <= s1_valid_q ? s1_owner_q : '0;
      rsp_transp_q <= s1_valid_q && (rom_addr_q == TRANSP_IDX);
      // The colour is held between responses.
      if (s1_valid_q) begin
        rsp_color_q <= rom_color;
      end
    end
  end

  assign req_ready  = gnt_onehot;
  assign rom_addr   = rom_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_color  = rsp_color_q;
  assign rsp_transp = rsp_transp_q;

endmodule

// File: tb/tb_palette_arbiter.sv
// Bench for palette_arbiter. It runs directed scenarios and then random traffic against a
// transaction-level reference model: a rotating priority pointer plus a two-deep history of grants.
module tb_palette_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [2:0]  req_valid;
  logic [11:0] req_idx;
  logic [2:0]  req_ready;
  logic [3:0]  rom_addr;
  logic [11:0] rom_color;
  logic [2:0]  rsp_valid;
  logic [11:0] rsp_color;
  logic        rsp_transp;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_ptr;
  bit          h1_v, h2_v;
  int          h1_g, h2_g;
  logic [3:0]  h1_i, h2_i;
  logic [11:0] m_color;

  always #5 Clk = ~Clk;

  palette_arbiter dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_color (rom_color),
    .rsp_valid (rsp_valid),
    .rsp_color (rsp_color),
    .rsp_transp(rsp_transp)
  );

  function automatic logic [11:0] pal(input logic [3:0] i);
    case (i)
      4'd0:    return 12'h232;
      4'd1:    return 12'hDDB;
      4'd2:    return 12'h5A1;
      4'd3:    return 12'h07F;
      4'd4:    return 12'hC30;
      4'd5:    return 12'h888;
      4'd6:    return 12'h1E9;
      4'd7:    return 12'h640;
      4'd8:    return 12'hFFF;
      4'd9:    return 12'h30C;
      4'd10:   return 12'hA5A;
      4'd11:   return 12'h0F0;
      4'd12:   return 12'h9B2;
      4'd13:   return 12'h456;
      4'd14:   return 12'hE17;
      default: return 12'hD93;
    endcase
  endfunction

  assign rom_color = pal(rom_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ptr   = 0;
    h1_v    = 1'b0;
    h2_v    = 1'b0;
    h1_g    = 0;
    h2_g    = 0;
    h1_i    = '0;
    h2_i    = '0;
    m_color = '0;
  endtask

  // One clock cycle: drive the inputs, check the grant and the response, then advance the model.
  task automatic step(input logic [2:0] v, input logic [11:0] ix);
    int         g;
    logic [2:0] exp_rdy;
    logic [3:0] gi;
    @(negedge Clk);
    req_valid = v;
    req_idx   = ix;
    #1;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      if (g < 0 && v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
    end
    exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (h2_v) m_color = pal(h2_i);
    check_eq("rsp_valid", 32'(rsp_valid), h2_v ? 32'(1 << h2_g) : 32'd0);
    check_eq("rsp_color", 32'(rsp_color), 32'(m_color));
    check_eq("rsp_transp", 32'(rsp_transp), 32'(h2_v && h2_i == 4'd0));
    gi = (g >= 0) ? ix[g*4 +: 4] : 4'd0;
    @(posedge Clk);
    h2_v = h1_v;
    h2_g = h1_g;
    h2_i = h1_i;
    h1_v = (g >= 0);
    h1_g = (g >= 0) ? g : 0;
    h1_i = gi;
    if (g >= 0) m_ptr = (g + 1) % 3;
  endtask

  // Assert reset for one clock edge with every requester valid. Nothing may be granted, and all
  // registered outputs must read zero. Reset is released with the requests dropped.
  task automatic do_reset();
    @(negedge Clk);
    Reset_n   = 1'b0;
    req_valid = 3'b111;
    req_idx   = 12'h123;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_color", 32'(rsp_color), 32'd0);
    check_eq("rst_rsp_transp", 32'(rsp_transp), 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    model_clear();
    @(negedge Clk);
    req_valid = 3'b000;
    Reset_n   = 1'b1;
  endtask

  initial begin
    Reset_n   = 1'b1;
    req_valid = '0;
    req_idx   = '0;
    model_clear();
    do_reset();

    // Single lookup from requester 1, index 1.
    step(3'b010, {4'd0, 4'd1, 4'd0});
    step(3'b000, 12'h0);
    step(3'b000, 12'h0);
    check_eq("single_color_dbb", 32'(rsp_color), 32'h0DDB);

    // Transparent index from requester 0.
    step(3'b001, {4'd3, 4'd3, 4'd0});
    step(3'b000, 12'h0);
    step(3'b000, 12'h0);
    check_eq("transp_flag", 32'(rsp_transp), 32'd1);

    // Fairness: all requesters stay valid for six cycles.
    for (int c = 0; c < 6; c++) step(3'b111, {4'd8, 4'd1, 4'd0});
    step(3'b000, 12'h0);
    step(3'b000, 12'h0);

    // Skip idle: the pointer sits at 1 after granting 0, and only 0 is valid.
    step(3'b001, 12'h005);
    step(3'b001, 12'h006);
    step(3'b010, 12'h070);
    step(3'b000, 12'h0);
    step(3'b000, 12'h0);

    // Reset mid-flight: requester 2 is granted, then reset hits the next cycle.
    step(3'b100, {4'd9, 4'd0, 4'd0});
    do_reset();
    step(3'b000, 12'h0);
    step(3'b110, {4'd2, 4'd4, 4'd0});
    step(3'b000, 12'h0);
    step(3'b000, 12'h0);

    // Back-to-back: requester 2 with index 8, then requester 0 with index 15.
    step(3'b100, {4'd8, 4'd0, 4'd0});
    step(3'b001, {4'd0, 4'd0, 4'd15});
    step(3'b000, 12'h0);
    check_eq("b2b_first", 32'(rsp_color), 32'h0FFF);
    step(3'b000, 12'h0);
    check_eq("b2b_second", 32'(rsp_color), 32'h0D93);

    // Random traffic with an occasional reset.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(3'($urandom_range(0, 7)), 12'($urandom));
    end
    step(3'b000, 12'h0);
    step(3'b000, 12'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
